alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the team's 64-bit combinational ALU. It keeps the existing 4-bit operation encodings and adds signed compare, shifts and an iterative multi-cycle multiply. Operands and results move over valid/ready handshakes on both sides. The `zero` flag is always derived from the result it is reported with. The block sits between operand fetch and writeback in the datapath and can accept one single-cycle operation per clock.

## Interface
- `WIDTH`, 64: operand/result width; must be ≥ 4 and a power of two.
- `MUL_EN`, 1: 1 implements MUL; 0 makes opcode 1000 illegal.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operand/opcode valid.
- `in_ready`  out  1  block can accept; transfer when `in_valid & in_ready` at a rising edge.
- `a`, `b`  in  WIDTH  operands.
- `alu_op`  in  4  operation select.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid & out_ready`.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  1 iff `result == 0` for the presented result.
- `illegal`  out  1  presented result came from an unknown or disabled opcode.

## Operation
- Opcodes and results (a, b unsigned unless stated; SH = b[log2(WIDTH)-1:0]):
  - 0000 AND: a&b
  - 0001 OR: a|b
  - 0010 ADD: a+b, carry discarded
  - 0110 SUB: a-b, mod 2^WIDTH
  - 1100 NOR: ~(a|b)
  - 0111 SLT: 1 if signed a < signed b, else 0
  - 0011 SLL: a<<SH
  - 0100 SRL: a>>SH, logical
  - 0101 SRA: a>>>SH, arithmetic
  - 1000 MUL: low WIDTH bits of a*b
- Any other opcode, or 1000 with `MUL_EN`=0: `result`=0, `zero`=1, `illegal`=1.
- `illegal`=0 for all legal ops.
- States:
  - IDLE: no result held.
  - BUSY: multiply iterating.
  - DONE: result held on outputs.
- Transitions:
  - IDLE + accept of a non-MUL op → DONE.
  - IDLE + accept of MUL → BUSY.
  - BUSY → DONE after the last iteration.
  - DONE + output transfer with no new accept → IDLE.
  - DONE + output transfer + accept → DONE (non-MUL) or BUSY (MUL).
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and `out_ready`, and is 0 in BUSY.
- Operands are captured on accept; `a`, `b` and `alu_op` may change freely afterwards.
- MUL datapath is shift-add with a count register of log2(WIDTH) bits. On each BUSY edge:
  - if multiplier[0]: acc += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count == WIDTH-1: latch acc into `result` and go to DONE.
- `result`, `zero` and `illegal` update only on the edge that enters DONE. They are stable while `out_valid`=1 and `out_ready`=0.
- `zero` is computed from the value being written into `result`, never from the previous result.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `out_valid`=0, `result`=0, `zero`=0, `illegal`=0, count and accumulator=0. `in_ready`=1 while in reset and immediately after.
- Non-MUL latency: accept at edge N → `out_valid`=1 after edge N. Back-to-back throughput is one op per clock while `out_ready`=1.
- MUL latency: accept at edge N → BUSY for WIDTH edges → `out_valid`=1 after edge N+WIDTH. Throughput is one MUL per WIDTH+1 cycles at best.
- Backpressure: while DONE and `out_ready`=0, `in_ready`=0, and `result`, `zero` and `illegal` hold unchanged.
- Simultaneous output transfer and input accept in DONE: the old result leaves and the new op is captured at the same edge, with no bubble.
- Reset mid-BUSY or mid-DONE: the operation is abandoned and all outputs return to reset values asynchronously. No result is presented after reset releases.
- `in_valid` deasserted in IDLE: no state change, outputs hold their reset or last-idle values, `out_valid`=0.

## Test plan
- Reset then ADD: a=0xFFFF_FFFF_FFFF_FFFF, b=1, `out_ready`=1 → `out_valid` one cycle after accept, `result`=0, `zero`=1, `illegal`=0.
- Back-to-back: 4 ops in consecutive cycles (AND 0xF0&0x3C, OR, SUB 5-7, NOR 0,0) → results 0x30, then the OR result, 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF; one per cycle, `in_ready` stays 1.
- MUL at WIDTH=64: a=0x1_0000_0003, b=5 → `in_ready`=0 for 64 cycles, then `result`=0x5_0000_000F, `zero`=0. Also a=2^63, b=2 → `result`=0, `zero`=1.
- Shifts and SLT at WIDTH=8:
  - SRA a=0x80, b=3 → 0xF0
  - SRL → 0x10
  - SLL a=0x81, b=1 → 0x02
  - SLT a=0xFF, b=0x01 → 1
- Backpressure and illegal op: hold `out_ready`=0 for 10 cycles → `result` stable and `in_ready`=0; then opcode 1111 → `result`=0, `zero`=1, `illegal`=1. With `MUL_EN`=0, opcode 1000 gives the same response.
- Reset asserted 10 cycles into a MUL → outputs zero immediately. After release, a fresh ADD 2+3 yields 5 with no stale output.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshakes and iterative shift-add multiply
// Single-cycle ops complete on the accepting edge; MUL iterates WIDTH edges in BUSY.
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] op_res;
  logic [SW-1:0]    count;
  logic [SW-1:0]    sh;
  logic             accept;
  logic             op_ill;
  logic             op_mul;

  assign sh       = b[SW-1:0];
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    op_mul = 1'b0;
    case (alu_op)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: op_res = a + b;
      4'b0110: op_res = a - b;
      4'b1100: op_res = ~(a | b);
      4'b0111: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: op_res = a << sh;
      4'b0100: op_res = a >> sh;
      4'b0101: op_res = $signed(a) >>> sh;
      4'b1000: begin
        if (MUL_EN) op_mul = 1'b1;
        else        op_ill = 1'b1;
      end
      default: op_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_next;
            zero      <= (acc_next == '0);
            illegal   <= 1'b0;
          end
        end
        default: begin
          // An accept in DONE overrides the drain to IDLE so there is no bubble.
          if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (op_mul) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              acc       <= '0;
              mcand     <= a;
              mplier    <= b;
              count     <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op_res;
              zero      <= (op_res == '0);
              illegal   <= op_ill;
            end
          end
        end
      endcase
    end
  end

endmodule
